// File: rtl/pcie_pipe_rate_ctrl.sv
// Link-wide Gen1/Gen2 rate-change and PIPE clock sequencer.
// Reprograms GT rate on all lanes, waits for every lane's rate-done (or a
// bounded timeout), switches pclk between 125/250 MHz, lets it settle, then
// returns a one-cycle PHYSTATUS pulse. PIPE clock buffers stay gated until
// the synchronized MMCM lock is high.
module pcie_pipe_rate_ctrl #(
  parameter int unsigned PCIE_LANE      = 1,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rate_i,
  input  logic                 mmcm_lock_i,
  input  logic [PCIE_LANE-1:0] gt_ratedone_i,
  output logic [2:0]           gt_rate_o,
  output logic [PCIE_LANE-1:0] pclk_sel_o,
  output logic                 pipeclk_en_o,
  output logic [PCIE_LANE-1:0] phystatus_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [PCIE_LANE-1:0] LANES_ALL = {PCIE_LANE{1'b1}};

  typedef enum logic [2:0] {
    S_LOCK_WAIT = 3'd0,
    S_IDLE      = 3'd1,
    S_RATE_WAIT = 3'd2,
    S_PCLK_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 lock_meta_q, lock_meta_d;
  logic                 lock_sync_q, lock_sync_d;
  logic [2:0]           gt_rate_q, gt_rate_d;
  logic [PCIE_LANE-1:0] pclk_sel_q, pclk_sel_d;
  logic                 pipeclk_en_q, pipeclk_en_d;
  logic [PCIE_LANE-1:0] phystatus_q, phystatus_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic                 rate_q, rate_d;
  logic                 new_rate_q, new_rate_d;
  logic [PCIE_LANE-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 all_done_c;

  // Register stage: state, outputs, lock synchronizer and bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_LOCK_WAIT;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      gt_rate_q    <= 3'b000;
      pclk_sel_q   <= '0;
      pipeclk_en_q <= 1'b0;
      phystatus_q  <= '0;
      busy_q       <= 1'b1;
      timeout_q    <= 1'b0;
      rate_q       <= 1'b0;
      new_rate_q   <= 1'b0;
      sticky_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      lock_meta_q  <= lock_meta_d;
      lock_sync_q  <= lock_sync_d;
      gt_rate_q    <= gt_rate_d;
      pclk_sel_q   <= pclk_sel_d;
      pipeclk_en_q <= pipeclk_en_d;
      phystatus_q  <= phystatus_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      rate_q       <= rate_d;
      new_rate_q   <= new_rate_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and registered-output logic; lock loss overrides everything
  always_comb begin
    state_d      = state_q;
    lock_meta_d  = mmcm_lock_i;
    lock_sync_d  = lock_meta_q;
    gt_rate_d    = gt_rate_q;
    pclk_sel_d   = pclk_sel_q;
    pipeclk_en_d = pipeclk_en_q;
    phystatus_d  = '0;
    timeout_d    = timeout_q;
    rate_d       = rate_q;
    new_rate_d   = new_rate_q;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;
    // Rate-done pulses landing on the exit cycle still count toward completion
    all_done_c   = &(sticky_q | gt_ratedone_i);

    if ((state_q != S_LOCK_WAIT) && !lock_sync_q) begin
      state_d      = S_LOCK_WAIT;
      pipeclk_en_d = 1'b0;
      sticky_d     = '0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        S_LOCK_WAIT: begin
          pipeclk_en_d = 1'b0;
          if (lock_sync_q) begin
            state_d      = S_IDLE;
            pipeclk_en_d = 1'b1;
          end
        end

        S_IDLE: begin
          if (rate_i != rate_q) begin
            state_d    = S_RATE_WAIT;
            gt_rate_d  = {2'b00, rate_i};
            new_rate_d = rate_i;
            sticky_d   = '0;
            cnt_d      = TIMEOUT_LOAD;
          end
        end

        S_RATE_WAIT: begin
          sticky_d = sticky_q | gt_ratedone_i;
          cnt_d    = cnt_q - CNT_ONE;
          if (all_done_c || (cnt_q == CNT_ONE)) begin
            if (!all_done_c) begin
              timeout_d = 1'b1;
            end
            state_d    = S_PCLK_WAIT;
            pclk_sel_d = {PCIE_LANE{new_rate_q}};
            cnt_d      = SETTLE_LOAD;
          end
        end

        S_PCLK_WAIT: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d     = S_DONE;
            phystatus_d = LANES_ALL;
          end
        end

        S_DONE: begin
          rate_d  = new_rate_q;
          state_d = S_IDLE;
        end

        default: begin
          state_d      = S_LOCK_WAIT;
          pipeclk_en_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign gt_rate_o    = gt_rate_q;
  assign pclk_sel_o   = pclk_sel_q;
  assign pipeclk_en_o = pipeclk_en_q;
  assign phystatus_o  = phystatus_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_pcie_pipe_rate_ctrl.sv
// Self-checking bench for pcie_pipe_rate_ctrl (4 lanes, short timeout).
// Expected behaviour comes from a timeline model: from the rate-done pulse
// schedule it derives the cycle at which all lanes are done (or the wait
// expires), and from that the pclk switch, PHYSTATUS and idle cycles.
module tb_pcie_pipe_rate_ctrl;

  localparam int LANES  = 4;
  localparam int SETTLE = 16;
  localparam int TMO    = 64;
  localparam int MAXC   = 128;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             rate_i;
  logic             mmcm_lock_i;
  logic [LANES-1:0] gt_ratedone_i;
  logic [2:0]       gt_rate_o;
  logic [LANES-1:0] pclk_sel_o;
  logic             pipeclk_en_o;
  logic [LANES-1:0] phystatus_o;
  logic             busy_o;
  logic             timeout_o;

  always #5 clk = ~clk;

  pcie_pipe_rate_ctrl #(
    .PCIE_LANE     (LANES),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rate_i       (rate_i),
    .mmcm_lock_i  (mmcm_lock_i),
    .gt_ratedone_i(gt_ratedone_i),
    .gt_rate_o    (gt_rate_o),
    .pclk_sel_o   (pclk_sel_o),
    .pipeclk_en_o (pipeclk_en_o),
    .phystatus_o  (phystatus_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse schedule, indexed by cycle offset from the request cycle
  logic [LANES-1:0] sched [MAXC];

  // Architectural view of the block as the bench believes it to be
  logic             m_rate;
  logic [2:0]       m_gt;
  logic [LANES-1:0] m_pclk;
  logic             m_tmo;

  typedef struct {
    logic rate;
    int   o0, o1, o2, o3;
    int   lrel;
    logic miss;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] e_gt, input logic [LANES-1:0] e_pclk,
                          input logic e_en, input logic [LANES-1:0] e_phys, input logic e_busy,
                          input logic e_tmo);
    chk({tag, " gt_rate"},    32'(gt_rate_o),    32'(e_gt));
    chk({tag, " pclk_sel"},   32'(pclk_sel_o),   32'(e_pclk));
    chk({tag, " pipeclk_en"}, 32'(pipeclk_en_o), 32'(e_en));
    chk({tag, " phystatus"},  32'(phystatus_o),  32'(e_phys));
    chk({tag, " busy"},       32'(busy_o),       32'(e_busy));
    chk({tag, " timeout"},    32'(timeout_o),    32'(e_tmo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched_clear();
    for (int i = 0; i < MAXC; i++) sched[i] = '0;
  endtask

  task automatic sched_set(input int off, input int lane);
    if (off >= 0 && off < MAXC) sched[off][lane] = 1'b1;
  endtask

  // Completion cycle: latest first in-window pulse across lanes, or the
  // full wait length when some lane never reports inside the window.
  task automatic model_lrel(output int lrel, output logic miss);
    int first;
    lrel = 0;
    miss = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      first = -1;
      for (int c = 1; c <= TMO; c++) if (first < 0 && sched[c][l]) first = c;
      if (first < 0) miss = 1'b1;
      else if (first > lrel) lrel = first;
    end
    if (miss) lrel = TMO;
  endtask

  // Idle cycles with stray rate-done pulses that must be ignored
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      gt_ratedone_i = 4'($urandom);
      chk_outs("idle", m_gt, m_pclk, 1'b1, '0, 1'b0, m_tmo);
    end
    gt_ratedone_i = '0;
  endtask

  // One full rate change starting in the current (IDLE) cycle; ends in the
  // first IDLE cycle after DONE. g_on/g_off flip rate_i while busy.
  task automatic run_seq(input string tag, input logic nr, input int lrel, input logic miss,
                         input int g_on, input int g_off);
    int last;
    last = lrel + SETTLE + 2;
    rate_i = nr;
    gt_ratedone_i = sched[0];
    for (int c = 1; c <= last; c++) begin
      tick();
      gt_ratedone_i = sched[c];
      if (c == g_on) rate_i = ~nr;
      if (c == g_off) rate_i = nr;
      chk_outs(tag, {2'b00, nr}, (c >= lrel + 1) ? {LANES{nr}} : m_pclk, 1'b1,
               (c == lrel + 1 + SETTLE) ? {LANES{1'b1}} : {LANES{1'b0}},
               (c < last), m_tmo | (miss && (c >= lrel + 1)));
    end
    gt_ratedone_i = '0;
    m_gt   = {2'b00, nr};
    m_pclk = {LANES{nr}};
    m_rate = nr;
    m_tmo  = m_tmo | miss;
  endtask

  initial begin
    logic nr;
    logic miss;
    int   lrel, last, g_on, g_off, off;
    logic stuck;

    vecs[0] = '{1'b1,  2,  5,  5,  9,  9, 1'b0};
    vecs[1] = '{1'b0, 64, 64, 64, 64, 64, 1'b0};
    vecs[2] = '{1'b1,  1,  1,  1,  1,  1, 1'b0};
    vecs[3] = '{1'b0,  3,  4, -1,  6, 64, 1'b1};
    vecs[4] = '{1'b1,  0,  7,  7,  7, 64, 1'b1};
    vecs[5] = '{1'b0, 65,  2,  2,  2, 64, 1'b1};

    m_rate = 1'b0; m_gt = 3'b000; m_pclk = '0; m_tmo = 1'b0;
    rst_i = 1'b1; rate_i = 1'b0; mmcm_lock_i = 1'b0; gt_ratedone_i = '0;

    // Reset values, then lock bring-up: enable and idle 3 cycles after lock
    #2;
    chk_outs("reset", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    tick(); tick(); tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_outs("nolock", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    end
    mmcm_lock_i = 1'b1;
    tick(); chk_outs("lock+1", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    tick(); chk_outs("lock+2", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    tick(); chk_outs("lock+3", 3'b000, '0, 1'b1, '0, 1'b0, 1'b0);
    idle_check(2);

    // Directed vectors: staggered, last-window-cycle, immediate, timeouts
    for (int i = 0; i < 6; i++) begin
      sched_clear();
      sched_set(vecs[i].o0, 0);
      sched_set(vecs[i].o1, 1);
      sched_set(vecs[i].o2, 2);
      sched_set(vecs[i].o3, 3);
      run_seq($sformatf("vec%0d", i), vecs[i].rate, vecs[i].lrel, vecs[i].miss, -1, -1);
      idle_check(2);
    end

    // rate_i toggles away while busy and stays: second sequence follows at once
    sched_clear();
    sched_set(2, 0); sched_set(2, 1); sched_set(3, 2); sched_set(3, 3);
    run_seq("glitch_a", 1'b1, 3, 1'b0, 2, -1);
    sched_clear();
    for (int l = 0; l < LANES; l++) sched_set(4, l);
    run_seq("glitch_b", 1'b0, 4, 1'b0, -1, -1);
    idle_check(2);

    // Randomized schedules with duplicate/late pulses and busy-time rate_i glitches
    for (int it = 0; it < 20; it++) begin
      nr = ~m_rate;
      sched_clear();
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(7, 0) == 0) off = int'($urandom_range(TMO + 6, TMO - 4));
        else off = int'($urandom_range(30, 0));
        sched_set(off, l);
        if ($urandom_range(1, 0) == 1) sched_set(int'($urandom_range(TMO + SETTLE, 0)), l);
      end
      model_lrel(lrel, miss);
      last  = lrel + SETTLE + 2;
      g_on  = -1;
      g_off = -1;
      stuck = 1'b0;
      case ($urandom_range(2, 0))
        1: begin
          g_on  = int'($urandom_range(last - 1, 1));
          g_off = int'($urandom_range(last, g_on + 1));
        end
        2: begin
          g_on  = int'($urandom_range(last - 1, 1));
          stuck = 1'b1;
        end
        default: ;
      endcase
      run_seq($sformatf("rand%0d", it), nr, lrel, miss, g_on, g_off);
      if (!stuck) idle_check(int'($urandom_range(3, 0)));
    end
    idle_check(1);

    // Lock loss during PCLK_WAIT aborts without PHYSTATUS; relock reruns
    nr = ~m_rate;
    sched_clear();
    for (int l = 0; l < LANES; l++) sched_set(2, l);
    rate_i = nr;
    gt_ratedone_i = sched[0];
    for (int c = 1; c <= 8; c++) begin
      tick();
      gt_ratedone_i = sched[c];
      chk_outs("ll_pre", {2'b00, nr}, (c >= 3) ? {LANES{nr}} : m_pclk, 1'b1, '0, 1'b1, m_tmo);
    end
    mmcm_lock_i = 1'b0;
    for (int c = 9; c <= 10; c++) begin
      tick();
      chk_outs("ll_sync", {2'b00, nr}, {LANES{nr}}, 1'b1, '0, 1'b1, m_tmo);
    end
    for (int c = 11; c <= 40; c++) begin
      tick();
      chk_outs("ll_wait", {2'b00, nr}, {LANES{nr}}, 1'b0, '0, 1'b1, m_tmo);
    end
    m_gt   = {2'b00, nr};
    m_pclk = {LANES{nr}};
    mmcm_lock_i = 1'b1;
    tick(); chk_outs("relock+1", m_gt, m_pclk, 1'b0, '0, 1'b1, m_tmo);
    tick(); chk_outs("relock+2", m_gt, m_pclk, 1'b0, '0, 1'b1, m_tmo);
    tick(); chk_outs("relock+3", m_gt, m_pclk, 1'b1, '0, 1'b0, m_tmo);
    sched_clear();
    for (int l = 0; l < LANES; l++) sched_set(5, l);
    run_seq("relock_seq", nr, 5, 1'b0, -1, -1);
    idle_check(2);

    // Asynchronous reset mid-RATE_WAIT: outputs reset without a clock edge
    nr = ~m_rate;
    sched_clear();
    for (int l = 0; l < LANES; l++) sched_set(3, l);
    rate_i = nr;
    tick();
    tick();
    chk_outs("pre_rst", {2'b00, nr}, m_pclk, 1'b1, '0, 1'b1, m_tmo);
    #2;
    rst_i = 1'b1;
    #1;
    chk_outs("async_rst", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    rate_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      gt_ratedone_i = 4'hF;
      chk_outs("in_rst", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    end
    gt_ratedone_i = '0;
    rst_i = 1'b0;
    m_rate = 1'b0; m_gt = 3'b000; m_pclk = '0; m_tmo = 1'b0;
    tick(); chk_outs("post_rst+1", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    tick(); chk_outs("post_rst+2", 3'b000, '0, 1'b0, '0, 1'b1, 1'b0);
    tick(); chk_outs("post_rst+3", 3'b000, '0, 1'b1, '0, 1'b0, 1'b0);
    sched_clear();
    sched_set(4, 0); sched_set(1, 1); sched_set(7, 2); sched_set(2, 3);
    run_seq("post_rst_seq", 1'b1, 7, 1'b0, -1, -1);
    idle_check(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net: the stimulus above is bounded, this only guards a stuck clock
  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
